// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: RF read, operand capture, forwarding and load-use stall.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB forwarding plus WB write-through.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CTRLW = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [4:0]       in_rd,
   input  logic             in_rd_we,
   input  logic             in_is_load,
   input  logic [CTRLW-1:0] in_ctrl,
   output logic [4:0]       rf_raddr1,
   output logic [4:0]       rf_raddr2,
   input  logic [XLEN-1:0]  rf_rdata1,
   input  logic [XLEN-1:0]  rf_rdata2,
   input  logic [4:0]       exm_rd,
   input  logic             exm_we,
   input  logic             exm_is_load,
   input  logic [XLEN-1:0]  exm_data,
   input  logic [4:0]       wb_rd,
   input  logic             wb_we,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [XLEN-1:0]  out_op1,
   output logic [XLEN-1:0]  out_op2,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic             out_rd_we,
   output logic             out_is_load,
   output logic [CTRLW-1:0] out_ctrl
);

   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] op1_q;
   logic [XLEN-1:0] op2_q;
   logic [XLEN-1:0] op1_cap;
   logic [XLEN-1:0] op2_cap;

   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

`ifdef ID_EX_FWD_EN
   logic ld_pend;
   logic rs1_ld;
   logic rs2_ld;

   assign ld_pend = out_valid & out_is_load & out_rd_we & (out_rd != 5'd0);
   assign rs1_ld  = ld_pend & (out_rd == in_rs1);
   assign rs2_ld  = ld_pend & (out_rd == in_rs2);
   assign hazard  = rs1_ld | rs2_ld;
`else
   // Without forwarding, wait until every in-flight writer of a source has retired.
   logic held_wr;
   logic rs1_busy;
   logic rs2_busy;
   logic unused_nofwd;

   assign held_wr  = out_valid & out_rd_we;
   assign rs1_busy = (in_rs1 != 5'd0)
                   & ((held_wr & (out_rd == in_rs1))
                   | (exm_we & (exm_rd == in_rs1))
                   | (wb_we & (wb_rd == in_rs1)));
   assign rs2_busy = (in_rs2 != 5'd0)
                   & ((held_wr & (out_rd == in_rs2))
                   | (exm_we & (exm_rd == in_rs2))
                   | (wb_we & (wb_rd == in_rs2)));
   assign hazard   = rs1_busy | rs2_busy;
   assign unused_nofwd = ^{exm_data, exm_is_load, wb_data};
`endif

   assign in_ready = (!out_valid | out_ready) & !hazard & !flush;
   assign accept   = in_valid & in_ready;

   always_comb begin
      op1_cap = rf_rdata1;
      op2_cap = rf_rdata2;
      out_op1 = op1_q;
      out_op2 = op2_q;
`ifdef ID_EX_FWD_EN
      // RF write lands on the next edge, so take WB data directly.
      if (wb_we && (wb_rd == in_rs1))
         op1_cap = wb_data;
      if (wb_we && (wb_rd == in_rs2))
         op2_cap = wb_data;
      if (exm_we && !exm_is_load && (exm_rd == out_rs1))
         out_op1 = exm_data;
      else if (wb_we && (wb_rd == out_rs1))
         out_op1 = wb_data;
      if (exm_we && !exm_is_load && (exm_rd == out_rs2))
         out_op2 = exm_data;
      else if (wb_we && (wb_rd == out_rs2))
         out_op2 = wb_data;
`endif
      if (in_rs1 == 5'd0)
         op1_cap = '0;
      if (in_rs2 == 5'd0)
         op2_cap = '0;
      if (out_rs1 == 5'd0)
         out_op1 = '0;
      if (out_rs2 == 5'd0)
         out_op2 = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_imm     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
         out_is_load <= 1'b0;
         out_ctrl    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_pc      <= in_pc;
         out_imm     <= in_imm;
         op1_q       <= op1_cap;
         op2_q       <= op2_cap;
         out_rs1     <= in_rs1;
         out_rs2     <= in_rs2;
         out_rd      <= in_rd;
         out_rd_we   <= in_rd_we;
         out_is_load <= in_is_load;
         out_ctrl    <= in_ctrl;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Random-stream bench for id_ex_stage against an in-order architectural model.
// Honours ID_EX_FWD_EN to pick the expected stall rule.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CTRLW = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc;
   logic [XLEN-1:0]  in_imm;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic [4:0]       in_rd;
   logic             in_rd_we;
   logic             in_is_load;
   logic [CTRLW-1:0] in_ctrl;
   logic [4:0]       rf_raddr1;
   logic [4:0]       rf_raddr2;
   logic [XLEN-1:0]  rf_rdata1;
   logic [XLEN-1:0]  rf_rdata2;
   logic [4:0]       exm_rd;
   logic             exm_we;
   logic             exm_is_load;
   logic [XLEN-1:0]  exm_data;
   logic [4:0]       wb_rd;
   logic             wb_we;
   logic [XLEN-1:0]  wb_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_imm;
   logic [XLEN-1:0]  out_op1;
   logic [XLEN-1:0]  out_op2;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic             out_rd_we;
   logic             out_is_load;
   logic [CTRLW-1:0] out_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [7:0]  ctrl;
   } ins_t;

   typedef struct packed {
      logic        v;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [31:0] data;
   } slot_t;

   logic [31:0] rf   [32];
   logic [31:0] gold [32];
   ins_t        q [$];
   ins_t        cur;
   ins_t        h;
   bit          have;
   slot_t       exs;
   slot_t       wbs;
   int          checks;
   int          failures;

   assign rf_rdata1   = rf[in_rs1];
   assign rf_rdata2   = rf[in_rs2];
   assign exm_rd      = exs.rd;
   assign exm_we      = exs.v & exs.we;
   assign exm_is_load = exs.v & exs.ld;
   assign exm_data    = exs.data;
   assign wb_rd       = wbs.rd;
   assign wb_we       = wbs.v & wbs.we;
   assign wb_data     = wbs.data;

   id_ex_stage #(.XLEN(XLEN), .CTRLW(CTRLW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .exm_rd(exm_rd), .exm_we(exm_we),
      .exm_is_load(exm_is_load), .exm_data(exm_data),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_op1(out_op1), .out_op2(out_op2),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load),
      .out_ctrl(out_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // A source must wait while an older instruction that will write it is
   // still unable to supply its value.
   function automatic bit stall_on(input logic [4:0] rs);
      if (rs == 5'd0)
         return 1'b0;
`ifdef ID_EX_FWD_EN
      return (q.size() > 0) && q[0].ld && q[0].we && (q[0].rd == rs);
`else
      return ((q.size() > 0) && q[0].we && (q[0].rd == rs))
          || (exs.v && exs.we && (exs.rd == rs))
          || (wbs.v && wbs.we && (wbs.rd == rs));
`endif
   endfunction

   task automatic commit_pending();
      for (int r = 0; r < 32; r++)
         rf[r] = gold[r];
      exs = '0;
      wbs = '0;
      q.delete();
   endtask

   initial begin
      bit exp_rdy;
      bit acc;
      bit iss;
      bit rchk;
      logic ldf;

      checks   = 0;
      failures = 0;
      have     = 0;
      rchk     = 0;
      exs      = '0;
      wbs      = '0;
      for (int r = 0; r < 32; r++) begin
         rf[r]   = (r == 0) ? 32'd0 : $urandom;
         gold[r] = rf[r];
      end
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_pc      = '0;
      in_imm     = '0;
      in_rs1     = '0;
      in_rs2     = '0;
      in_rd      = '0;
      in_rd_we   = 1'b0;
      in_is_load = 1'b0;
      in_ctrl    = '0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid0", out_valid, 0);
      check("rst_pc0", out_pc, 0);
      check("rst_ctrl0", out_ctrl, 0);
      rst_n = 1'b1;
      rchk  = 1;

      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", out_valid, 0);
            check("rst_op1", out_op1, 0);
            commit_pending();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            rchk  = 1;
         end

         if (!have) begin
            cur.pc   = $urandom;
            cur.imm  = $urandom;
            cur.rs1  = 5'($urandom_range(0, 4));
            cur.rs2  = 5'($urandom_range(0, 4));
            cur.rd   = 5'($urandom_range(0, 4));
            cur.we   = ($urandom_range(0, 9) < 8);
            cur.ld   = ($urandom_range(0, 9) < 3);
            cur.ctrl = 8'($urandom);
            have     = 1;
         end
         in_valid   = ($urandom_range(0, 9) < 7);
         in_pc      = cur.pc;
         in_imm     = cur.imm;
         in_rs1     = cur.rs1;
         in_rs2     = cur.rs2;
         in_rd      = cur.rd;
         in_rd_we   = cur.we;
         in_is_load = cur.ld;
         in_ctrl    = cur.ctrl;
         flush      = rchk ? 1'b0 : ($urandom_range(0, 29) == 0);
         out_ready  = (q.size() == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (flush && q.size() > 0)
            out_ready = 1'b0;

         @(negedge clk);
         exp_rdy = ((q.size() == 0) || out_ready)
                 && !stall_on(in_rs1) && !stall_on(in_rs2) && !flush;
         if (rchk)
            check("rst_rdy", in_ready, 1);
         rchk = 0;
         check("in_ready", in_ready, exp_rdy);
         check("raddr1", rf_raddr1, in_rs1);
         check("raddr2", rf_raddr2, in_rs2);
         check("out_valid", out_valid, q.size() > 0);
         if (q.size() > 0) begin
            h = q[0];
            check("pc", out_pc, h.pc);
            check("imm", out_imm, h.imm);
            check("rs1", out_rs1, h.rs1);
            check("rs2", out_rs2, h.rs2);
            check("rd", out_rd, h.rd);
            check("flags", {out_rd_we, out_is_load, out_ctrl},
                  {h.we, h.ld, h.ctrl});
            check("op1", out_op1, gold[h.rs1]);
            check("op2", out_op2, gold[h.rs2]);
         end
         if (out_valid) begin
            ldf = exm_we & exm_is_load & (exm_rd != 5'd0)
                & ((exm_rd == out_rs1) | (exm_rd == out_rs2));
            check("ld_fwd", ldf, 0);
         end
         acc = in_valid && exp_rdy;
         iss = (q.size() > 0) && out_ready;

         @(posedge clk);
         #1;
         if (wbs.v && wbs.we && wbs.rd != 5'd0)
            rf[wbs.rd] = wbs.data;
         if (out_ready) begin
            wbs = exs;
            exs = '0;
            if (iss) begin
               h        = q.pop_front();
               exs.v    = 1'b1;
               exs.rd   = h.rd;
               exs.we   = h.we;
               exs.ld   = h.ld;
               exs.data = $urandom;
               if (h.we && h.rd != 5'd0)
                  gold[h.rd] = exs.data;
            end
         end
         if (flush && q.size() > 0)
            void'(q.pop_front());
         if (acc) begin
            q.push_back(cur);
            have = 0;
         end else if (flush && in_valid) begin
            have = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the RISC-V core, directly downstream of the register file read ports. It drives the register file read addresses from the decoded instruction and captures the read data into the ID/EX pipeline register, along with PC, immediate and control. It forwards in-flight results from EX/MEM and MEM/WB and stalls decode for one cycle on a load-use hazard. It uses a valid/ready handshake on both sides.

## Interface
- XLEN, 32, datapath width
- CTRLW, 8, width of opaque control bundle passed to EX
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1  decode handshake
- in_pc, in_imm  in  XLEN  instruction PC, sign-extended immediate
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_rd_we, in_is_load  in  1  writes rd; instruction is a load
- in_ctrl  in  CTRLW  control bundle
- rf_raddr1, rf_raddr2  out  5  register file read addresses (= in_rs1, in_rs2, combinational)
- rf_rdata1, rf_rdata2  in  XLEN  register file combinational read data
- exm_rd, exm_we, exm_is_load, exm_data  in  5/1/1/XLEN  EX/MEM result
- wb_rd, wb_we, wb_data  in  5/1/XLEN  MEM/WB result (same as register file write port)
- flush  in  1  kill the held instruction and the incoming instruction
- out_valid / out_ready  out / in  1  execute handshake
- out_pc, out_imm, out_op1, out_op2  out  XLEN  held PC/imm; forwarded operands
- out_rs1, out_rs2, out_rd  out  5; out_rd_we, out_is_load  out  1; out_ctrl  out  CTRLW

## Operation
- hazard = out_valid & out_is_load & out_rd_we & out_rd≠0 & (out_rd==in_rs1 | out_rd==in_rs2).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- accept = in_valid & in_ready. On accept, all in_* fields are captured and out_valid is set to 1.
- Capture of operand n: 0 if rsn==0; wb_data if wb_we & wb_rd==rsn (write-through, because the register file write is not visible until the next edge); otherwise rf_rdatan.
- No accept while out_ready=1: out_valid is cleared (a bubble is inserted).
- No accept while out_ready=0: the register holds. A held instruction is not re-captured.
- Output forwarding for out_opn is combinational and uses priority order:
  - 0 if out_rsn==0;
  - exm_data if exm_we & !exm_is_load & exm_rd==out_rsn;
  - wb_data if wb_we & wb_rd==out_rsn;
  - otherwise the captured value.
- exm_is_load matching a valid out_rsn is unreachable by construction; the bench asserts it never occurs.
- flush: out_valid is cleared on the next edge, and the incoming instruction is dropped. flush has priority over accept and hold.
- out_ready=0 is pipeline-global: EX/MEM and MEM/WB are frozen, so the forwarding sources stay stable while the register holds.

## Timing
- Reset (async assert, sync release): out_valid=0; all out_* registers are 0. in_ready is 1 in the first cycle after release.
- Latency is one cycle from accept to out_valid.
- Throughput is one instruction per cycle with no hazard and out_ready=1.
- Load-use costs exactly one stall cycle:
  - cycle k: load in the register, hazard → in_ready=0, one-cycle bubble;
  - cycle k+1: consumer accepted;
  - cycle k+2: consumer forwarded from wb.
- Simultaneous out_ready=1 and accept: the old instruction leaves and the new one enters in the same edge.
- rst_n asserted mid-stall or mid-flush clears out_valid immediately.

## Configuration
- ID_EX_FWD_EN defined: forwarding and wb write-through are applied exactly as in Operation.
- ID_EX_FWD_EN undefined: no forwarding.
  - out_opn is the captured rf_rdatan (0 for x0).
  - hazard widens to a match of in_rs1/in_rs2 (≠0) against any valid writer: the held register (out_rd_we), exm (exm_we) or wb (wb_we).
  - Decode stalls until the register file holds the value.

## Test plan
- Reset: rst_n=0 mid-run → out_valid=0 and out_op1=0 asynchronously; after release, in_ready=1.
- EX forward: exm_rd=5, exm_we=1, exm_data=0xAAAA0001; held out_rs1=5 → out_op1=0xAAAA0001 while the register file still returns old data.
- Write-through: wb_rd=7, wb_we=1, wb_data=0x1234 in the same cycle as accepting in_rs2=7 → captured op2=0x1234. Repeat with in_rs2=0 → op2=0.
- Load-use: lw x3 held, add with rs1=3 at the input → in_ready=0 for 1 cycle, one bubble, then add is issued with out_op1=wb_data.
- Backpressure and flush:
  - out_ready=0 for 3 cycles → outputs stable and in_ready=0;
  - flush=1 with in_valid=1 → next cycle out_valid=0 and the incoming instruction is never issued.
- Macro off: the same load-use and ALU-use sequences stall until wb has written, and the operands match register file contents.
